// File: rtl/psram_responder.sv
`timescale 1ns / 1ps
// psram_responder: QSPI PSRAM device model, bus oversampled in the sysclk domain.
// Optional macro PSRAM_RESPONDER_WRAP_1K_EN: burst addresses wrap inside the current 1 KiB page.
module psram_responder #(
    parameter int unsigned MEM_AW      = 12,
    parameter int unsigned WAIT_CYCLES = 6
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ce_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic [7:0] reset_count,
    output logic       cmd_err,
    output logic [7:0] last_cmd
);

    typedef logic [MEM_AW-1:0] addr_t;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWait,
        StRdata,
        StWdata,
        StDone,
        StIgnore
    } state_e;

    localparam logic [7:0] CmdWrite = 8'h38;
    localparam logic [7:0] CmdRead  = 8'hEB;
    localparam logic [7:0] CmdRstEn = 8'h66;
    localparam logic [7:0] CmdRst   = 8'h99;
    localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES);

    // Bus synchronizers; sclk_prev is the third stage used for edge detection.
    logic [1:0] sclk_sync;
    logic [1:0] ce_sync;
    logic [3:0] sio_sync1;
    logic [3:0] sio_sync2;
    logic       sclk_prev;

    logic       sclk_s;
    logic       ce_s;
    logic [3:0] sio_s;
    logic       rise;
    logic       fall;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            ce_sync   <= 2'b11;
            sio_sync1 <= 4'h0;
            sio_sync2 <= 4'h0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ce_sync   <= {ce_sync[0], ce_n};
            sio_sync1 <= sio_in;
            sio_sync2 <= sio_sync1;
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_s = sclk_sync[1];
    assign ce_s   = ce_sync[1];
    assign sio_s  = sio_sync2;
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    // Controller state
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    addr_t      addr_q, addr_d;
    logic [3:0] wbuf_q, wbuf_d;
    logic       lo_next_q, lo_next_d;
    logic       rd_q, rd_d;
    logic [3:0] out_q, out_d;
    logic       oe_q, oe_d;
    logic       arm_q, arm_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic       err_q, err_d;
    logic [7:0] last_q, last_d;

    logic [7:0] cmd_byte;
    logic       mem_we;
    logic [7:0] mem_rd;
    addr_t      addr_inc;
    addr_t      addr_next;

    logic [7:0] mem [0:(1 << MEM_AW) - 1];

    assign mem_rd = mem[addr_q];

    // Memory has no reset; contents survive both rst_n and software reset.
    always_ff @(posedge sysclk) begin
        if (mem_we) begin
            mem[addr_q] <= {wbuf_q, sio_s};
        end
    end

`ifdef PSRAM_RESPONDER_WRAP_1K_EN
    localparam addr_t PageMask = addr_t'(10'h3FF);

    always_comb begin
        addr_inc  = addr_q + addr_t'(1);
        addr_next = (addr_q & ~PageMask) | (addr_inc & PageMask);
    end
`else
    always_comb begin
        addr_inc  = addr_q + addr_t'(1);
        addr_next = addr_inc;
    end
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'h00;
            shift_q   <= 7'h00;
            addr_q    <= '0;
            wbuf_q    <= 4'h0;
            lo_next_q <= 1'b0;
            rd_q      <= 1'b0;
            out_q     <= 4'h0;
            oe_q      <= 1'b0;
            arm_q     <= 1'b0;
            rcnt_q    <= 8'h00;
            err_q     <= 1'b0;
            last_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wbuf_q    <= wbuf_d;
            lo_next_q <= lo_next_d;
            rd_q      <= rd_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            arm_q     <= arm_d;
            rcnt_q    <= rcnt_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        lo_next_d = lo_next_q;
        rd_d      = rd_q;
        out_d     = out_q;
        oe_d      = oe_q;
        arm_d     = arm_q;
        rcnt_d    = rcnt_q;
        err_d     = 1'b0;
        last_d    = last_q;
        mem_we    = 1'b0;
        cmd_byte  = {shift_q, sio_s[0]};

        // Deselect aborts whatever is in flight; partial bytes are simply dropped.
        if (ce_s) begin
            state_d = StIdle;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCmd;
                    cnt_d   = 8'h00;
                end
                StCmd: begin
                    if (rise) begin
                        shift_d = cmd_byte[6:0];
                        cnt_d   = cnt_q + 8'h01;
                        if (cnt_q == 8'h07) begin
                            cnt_d  = 8'h00;
                            last_d = cmd_byte;
                            arm_d  = 1'b0;
                            rd_d   = (cmd_byte == CmdRead);
                            case (cmd_byte)
                                CmdWrite, CmdRead: state_d = StAddr;
                                CmdRstEn: begin
                                    state_d = StDone;
                                    arm_d   = 1'b1;
                                end
                                CmdRst: begin
                                    state_d = StDone;
                                    if (arm_q) begin
                                        rcnt_d = rcnt_q + 8'h01;
                                    end
                                end
                                default: begin
                                    state_d = StIgnore;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (rise) begin
                        // Shifting through an MEM_AW-wide register keeps only the low bits.
                        addr_d = addr_t'({addr_q, sio_s});
                        cnt_d  = cnt_q + 8'h01;
                        if (cnt_q == 8'h05) begin
                            cnt_d     = 8'h00;
                            lo_next_d = 1'b0;
                            state_d   = rd_q ? StWait : StWdata;
                        end
                    end
                end
                StWait: begin
                    if (rise && (cnt_q < WaitLast)) begin
                        cnt_d = cnt_q + 8'h01;
                    end else if (fall && (cnt_q >= WaitLast)) begin
                        oe_d      = 1'b1;
                        out_d     = mem_rd[7:4];
                        lo_next_d = 1'b1;
                        state_d   = StRdata;
                    end
                end
                StRdata: begin
                    if (fall) begin
                        if (lo_next_q) begin
                            out_d     = mem_rd[3:0];
                            addr_d    = addr_next;
                            lo_next_d = 1'b0;
                        end else begin
                            out_d     = mem_rd[7:4];
                            lo_next_d = 1'b1;
                        end
                    end
                end
                StWdata: begin
                    if (rise) begin
                        if (lo_next_q) begin
                            mem_we    = 1'b1;
                            addr_d    = addr_next;
                            lo_next_d = 1'b0;
                        end else begin
                            wbuf_d    = sio_s;
                            lo_next_d = 1'b1;
                        end
                    end
                end
                StDone, StIgnore: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign sio_out     = out_q;
    assign sio_oe      = oe_q;
    assign reset_count = rcnt_q;
    assign cmd_err     = err_q;
    assign last_cmd    = last_q;

endmodule

// File: doc/psram_responder.md
# psram_responder

Synthesizable QSPI responder that models the IPS6404L-class PSRAM device at the far end of the SPI/QSPI bus driven by the board PSRAM controller. It oversamples the bus in the `sysclk` domain and decodes the reset-enable, reset, quad write and quad fast-read commands. It stores data in an internal byte array and drives read data back on the shared SIO lines. It is used as the device in on-board loopback tests and as the DUT-side memory in controller simulations.

## Interface
- `MEM_AW`, 12: internal memory address width; depth is 2^MEM_AW bytes.
- `WAIT_CYCLES`, 6: number of dummy SCLK cycles between the address and the first read nibble for fast read.
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sclk`  in  1  bus serial clock, asynchronous to `sysclk`.
- `ce_n`  in  1  chip enable, active-low.
- `sio_in`  in  4  bus data lines; `sio_in[0]` is SI in SPI mode.
- `sio_out`  out  4  read data nibble.
- `sio_oe`  out  1  output enable for `sio_out`.
- `reset_count`  out  8  number of completed software resets; wraps 255→0.
- `cmd_err`  out  1  one-cycle pulse when an unsupported command is received.
- `last_cmd`  out  8  last fully received command byte.

## Operation
- `sclk`, `ce_n` and `sio_in` each pass through 2-flop synchronizers. Edges are detected against a third register, giving an `sclk` rise event and an `sclk` fall event.
- States and transitions:
  - IDLE → CMD on `ce_n` low.
  - CMD: 8 rise events, one bit per event from `sio_in[0]`, MSB first.
    - 0x38 → ADDR (write).
    - 0xEB → ADDR (read).
    - 0x66 → DONE, arm set.
    - 0x99 → DONE; if armed, `reset_count`+1 and arm cleared.
    - Any other value → IGNORE, `cmd_err` pulse.
  - Any completed command other than 0x66 clears arm.
  - ADDR: 6 rise events, one nibble each, MSB nibble first, into a 24-bit address. Only the low MEM_AW bits index memory. Write goes to WDATA; read goes to WAIT.
  - WAIT: counts WAIT_CYCLES rise events. On the fall event following the last wait rise, asserts `sio_oe` and drives the high nibble of mem[addr] → RDATA.
  - RDATA: each fall event drives the next nibble, high then low. The address increments after the low nibble is driven.
  - WDATA: each rise event captures a nibble, high first. On the low nibble, mem[addr] is written and addr increments.
- Rising `ce_n`, seen in any state, → IDLE and clears `sio_oe`. A partial byte, partial address or half-written byte is discarded; memory is untouched.
- Address increment wraps modulo 2^MEM_AW.
- Software reset (0x66 then 0x99) does not clear memory. It only counts and returns to IDLE.
- `rst_n` low: state IDLE, arm 0, `sio_out` 0, `sio_oe` 0, `reset_count` 0, `cmd_err` 0, `last_cmd` 0. Memory contents are undefined and not cleared. Reset mid-transfer aborts it.

## Timing
- `sclk` frequency ≤ `sysclk`/4. `sclk` high and low each ≥ 2 `sysclk` periods.
- Input capture latency: 3 `sysclk` cycles from a bus edge to the internal event.
- Output latency: `sio_out`/`sio_oe` update 1 `sysclk` after the fall event, i.e. ≤ 4 `sysclk` after the `sclk` falling edge. This is within the half SCLK period before the controller samples on the rise.
- Memory write: 1 `sysclk` after the low-nibble rise event.
- `cmd_err`: high exactly 1 `sysclk`, on the cycle after the 8th command bit.
- `ce_n` deassert to `sio_oe` low: ≤ 4 `sysclk`.

## Configuration
- `PSRAM_RESPONDER_WRAP_1K_EN`:
  - Defined: burst address increments wrap within the current 1 KiB page, so addr[9:0] wraps and the upper bits are held. This matches the device's page-boundary behaviour.
  - Undefined: linear increment modulo 2^MEM_AW.

## Test plan
- Write 0x38 to address 0x000010 with data A5 3C 0F F0, `ce_n` high, then 0xEB read of 4 bytes from 0x000010 → read returns A5 3C 0F F0. `sio_oe` rises after the 6th wait cycle and falls within 4 `sysclk` of `ce_n` high.
- 0x66 (`ce_n` toggle), then 0x99 → `reset_count` 0→1. Memory is still readable with its prior contents.
- 0x66, then 0x38 with no data, then 0x99 → `reset_count` unchanged, because the arm is cleared.
- Write 0x38 at 0x000020 with `ce_n` raised after 1.5 bytes (A5, then nibble 3) → mem[0x20]=A5 and mem[0x21] is unchanged.
- Write 2 bytes at 0x0003FF:
  - With the macro: bytes land at 0x3FF and 0x000.
  - Without the macro (MEM_AW=12): bytes land at 0x3FF and 0x400.
- Command 0x9F → one `cmd_err` pulse, `last_cmd`=0x9F, `sio_oe` stays 0 until `ce_n` high.
